// File: rtl/hcms_pkg.sv
// hcms_pkg: shared state encoding, register-select levels and default control words for HCMS-29xx chains
package hcms_pkg;
  typedef enum logic [2:0] {RST_HOLD, IDLE, CTRL_SHIFT, FRAME_SHIFT, TAIL} state_t;
  localparam logic RS_CTRL = 1'b1;
  localparam logic RS_DOT = 1'b0;
  localparam logic [7:0] CW0_DEFAULT = 8'h4F;
  localparam logic [7:0] CW1_DEFAULT = 8'h81;
endpackage

// File: rtl/hcms_bit_shifter.sv
// hcms_bit_shifter: MSB-first byte serializer with a CLK_DIV half-period divider and a trailing low half period
module hcms_bit_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       r_reset,
  input  logic       start,
  input  logic [7:0] load_byte,
  output logic       byte_done,
  output logic       half_last,
  output logic       hcms_clk,
  output logic       hcms_data
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic          active, tail;
  logic [DW-1:0] div;
  logic [2:0]    bit_cnt;
  logic [6:0]    sr;
  assign half_last = active && div == DW'(CLK_DIV - 1);
  assign byte_done = half_last && hcms_clk && bit_cnt == 3'd7;
  // a byte that ends without a follow-on start gets one extra low half period (tail) before going idle
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      active <= 1'b0;
      tail <= 1'b0;
      hcms_clk <= 1'b0;
      hcms_data <= 1'b0;
      div <= '0;
      bit_cnt <= '0;
      sr <= '0;
    end else if (start) begin
      active <= 1'b1;
      tail <= 1'b0;
      hcms_clk <= 1'b0;
      hcms_data <= load_byte[7];
      sr <= load_byte[6:0];
      div <= '0;
      bit_cnt <= '0;
    end else if (half_last) begin
      div <= '0;
      if (tail) begin
        active <= 1'b0;
        tail <= 1'b0;
      end else begin
        hcms_clk <= ~hcms_clk;
        if (hcms_clk && bit_cnt == 3'd7) tail <= 1'b1;
        else if (hcms_clk) begin
          bit_cnt <= bit_cnt + 3'd1;
          hcms_data <= sr[6];
          sr <= {sr[5:0], 1'b0};
        end
      end
    end else if (active) div <= div + DW'(1);
  end
endmodule

// File: rtl/hcms_frame_ctrl.sv
// hcms_frame_ctrl: HCMS-29xx frame buffer, reset pulse and serial control/frame transmitter
// HCMS_AUTO_REFRESH_EN: when defined, any buffer write queues a frame refresh.
module hcms_frame_ctrl
  import hcms_pkg::*;
#(
  parameter int NUM_CHARS = 4,
  parameter int COLS_PER_CHAR = 5,
  parameter int CLK_DIV = 2,
  parameter int RESET_CYCLES = 16,
  localparam int NCOL = NUM_CHARS * COLS_PER_CHAR,
  localparam int AW = $clog2(NCOL)
) (
  input  logic          i_clk,
  input  logic          r_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_ctrl_valid,
  input  logic [7:0]    i_ctrl_data,
  output logic          o_ctrl_ready,
  input  logic          i_frame_start,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic          o_hcms_data,
  output logic          o_hcms_clk,
  output logic          o_hcms_rs,
  output logic          o_hcms_ce_n,
  output logic          o_hcms_reset_n
);
  localparam int CMAX = RESET_CYCLES > CLK_DIV ? RESET_CYCLES : CLK_DIV;
  localparam int CW = $clog2(CMAX + 1);
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] col, col_n;
  logic          drain, drain_n, frame_pend, frame_req, frame_done, enter_frame;
  logic          shift_start, byte_done, half_last;
  logic [7:0]    shift_byte;
  logic [7:0]    fbuf [NCOL];
  always_ff @(posedge i_clk)
    if (i_wr_en && int'(i_wr_addr) < NCOL) fbuf[i_wr_addr] <= i_wr_data;
  assign enter_frame = state == IDLE && state_n == FRAME_SHIFT;
`ifdef HCMS_AUTO_REFRESH_EN
  logic dirty;
  always_ff @(posedge i_clk)
    dirty <= r_reset ? 1'b0 : i_wr_en | (dirty & ~enter_frame);
  assign frame_req = frame_pend | dirty;
`else
  assign frame_req = frame_pend;
`endif
  // columns are fetched only when their byte starts, so late writes to unsent columns still make this frame
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    col_n = col;
    drain_n = drain;
    shift_start = 1'b0;
    shift_byte = i_ctrl_data;
    case (state)
      RST_HOLD: begin
        state_n = cnt == CW'(RESET_CYCLES - 1) ? IDLE : RST_HOLD;
        cnt_n = cnt == CW'(RESET_CYCLES - 1) ? '0 : cnt + CW'(1);
      end
      IDLE:
        if (i_ctrl_valid) begin
          shift_start = 1'b1;
          state_n = CTRL_SHIFT;
        end else if (frame_req) begin
          shift_start = 1'b1;
          shift_byte = fbuf[AW'(NCOL - 1)];
          col_n = AW'(NCOL - 1);
          state_n = FRAME_SHIFT;
        end
      CTRL_SHIFT, FRAME_SHIFT: begin
        if (byte_done && (state == CTRL_SHIFT || col == '0)) drain_n = 1'b1;
        else if (byte_done) begin
          shift_start = 1'b1;
          shift_byte = fbuf[col - AW'(1)];
          col_n = col - AW'(1);
        end
        if (drain && half_last) begin
          drain_n = 1'b0;
          state_n = TAIL;
        end
      end
      TAIL: begin
        state_n = cnt == CW'(CLK_DIV - 1) ? IDLE : TAIL;
        cnt_n = cnt == CW'(CLK_DIV - 1) ? '0 : cnt + CW'(1);
      end
      default: state_n = RST_HOLD;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      state <= RST_HOLD;
      cnt <= '0;
      col <= '0;
      drain <= 1'b0;
      frame_pend <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      col <= col_n;
      drain <= drain_n;
      frame_pend <= i_frame_start | (frame_pend & ~enter_frame);
      frame_done <= state == FRAME_SHIFT && state_n == TAIL;
    end
  end
  hcms_bit_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .i_clk    (i_clk),
    .r_reset  (r_reset),
    .start    (shift_start),
    .load_byte(shift_byte),
    .byte_done(byte_done),
    .half_last(half_last),
    .hcms_clk (o_hcms_clk),
    .hcms_data(o_hcms_data)
  );
  assign o_busy = state != IDLE;
  assign o_ctrl_ready = state == IDLE;
  assign o_hcms_reset_n = state != RST_HOLD;
  assign o_hcms_ce_n = !(state == CTRL_SHIFT || state == FRAME_SHIFT);
  assign o_hcms_rs = state == CTRL_SHIFT ? RS_CTRL : RS_DOT;
  assign o_frame_done = frame_done;
endmodule

// File: tb/tb_hcms_frame_ctrl.sv
// tb_hcms_frame_ctrl: directed checks of reset hold, control word, frame order/length, priority and mid-frame reset
module tb_hcms_frame_ctrl;
  logic       i_clk = 1'b0, r_reset = 1'b1;
  logic       i_wr_en = 1'b0, i_ctrl_valid = 1'b0, i_frame_start = 1'b0;
  logic [4:0] i_wr_addr = '0;
  logic [7:0] i_wr_data = '0, i_ctrl_data = '0;
  logic       o_ctrl_ready, o_busy, o_frame_done, o_hcms_data, o_hcms_clk, o_hcms_rs, o_hcms_ce_n, o_hcms_reset_n;
  int         passed = 0, total = 0, fails = 0;
  int         ce_low = 0, done_cnt = 0, done_bad = 0;
  logic       prev_ce = 1'b1;
  logic       bits[$];
  logic       rss[$];
  hcms_frame_ctrl dut (
    .i_clk(i_clk), .r_reset(r_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_ctrl_valid(i_ctrl_valid), .i_ctrl_data(i_ctrl_data), .o_ctrl_ready(o_ctrl_ready),
    .i_frame_start(i_frame_start), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_hcms_data(o_hcms_data),
    .o_hcms_clk(o_hcms_clk), .o_hcms_rs(o_hcms_rs), .o_hcms_ce_n(o_hcms_ce_n), .o_hcms_reset_n(o_hcms_reset_n)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge o_hcms_clk)
    if (!o_hcms_ce_n) begin
      bits.push_back(o_hcms_data);
      rss.push_back(o_hcms_rs);
    end
  always @(negedge i_clk) begin
    if (o_frame_done) begin
      done_cnt++;
      if (!(o_hcms_ce_n && !prev_ce)) done_bad++;
    end
    if (!o_hcms_ce_n) ce_low++;
    prev_ce = o_hcms_ce_n;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] byte_at(input int i);
    logic [7:0] b = '0;
    for (int j = 0; j < 8; j++) b = {b[6:0], bits[i+j]};
    return b;
  endfunction
  function automatic int rs_ones(input int s, input int n);
    int c = 0;
    for (int j = s; j < s + n; j++) c += int'(rss[j]);
    return c;
  endfunction
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    i_wr_en = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask
  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (!(done_cnt >= target && !o_busy) && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, 32'(n < 5000), 1);
  endtask
  task automatic hold_count(input string tag);
    int n = 0;
    while (!o_hcms_reset_n && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    chk(tag, n, 16);
  endtask
  initial begin
    int n, b0, c0;
    repeat (3) @(negedge i_clk);
    chk("rst_reset_n", o_hcms_reset_n, 0);
    chk("rst_ce_n", o_hcms_ce_n, 1);
    chk("rst_clk", o_hcms_clk, 0);
    chk("rst_data", o_hcms_data, 0);
    chk("rst_rs", o_hcms_rs, 0);
    chk("rst_busy", o_busy, 1);
    chk("rst_ready", o_ctrl_ready, 0);
    chk("rst_done", o_frame_done, 0);
    r_reset = 1'b0;
    hold_count("reset_hold_len");
    chk("idle_busy", o_busy, 0);
    chk("idle_ready", o_ctrl_ready, 1);
    // control word 0x81
    b0 = bits.size();
    c0 = ce_low;
    i_ctrl_valid = 1'b1;
    i_ctrl_data = 8'h81;
    @(negedge i_clk);
    i_ctrl_valid = 1'b0;
    n = 0;
    while (!o_ctrl_ready && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    chk("ctrl_ready_again", n, 36);
    chk("ctrl_ce_low", ce_low - c0, 34);
    chk("ctrl_nbits", bits.size() - b0, 8);
    chk("ctrl_byte", byte_at(b0), 8'h81);
    chk("ctrl_rs", rs_ones(b0, 8), 8);
    chk("ctrl_no_done", done_cnt, 0);
    // full frame
    wr(5'd0, 8'h7E);
    wr(5'd19, 8'h1C);
    b0 = bits.size();
    c0 = ce_low;
    i_frame_start = 1'b1;
    @(negedge i_clk);
    i_frame_start = 1'b0;
    wait_done(1, "frame1_finish");
    chk("frame1_nbits", bits.size() - b0, 160);
    chk("frame1_first", byte_at(b0), 8'h1C);
    chk("frame1_last", byte_at(b0 + 152), 8'h7E);
    chk("frame1_ce_low", ce_low - c0, 642);
    chk("frame1_done", done_cnt, 1);
    chk("frame1_done_at_ce_rise", done_bad, 0);
    chk("frame1_rs", rs_ones(b0, 160), 0);
    // writes during a frame: shifting column keeps old value, unsent column takes new one
    b0 = bits.size();
    i_frame_start = 1'b1;
    @(negedge i_clk);
    i_frame_start = 1'b0;
    n = 0;
    while (bits.size() - b0 < 2 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    wr(5'd19, 8'hAA);
    wr(5'd0, 8'h3C);
    wait_done(2, "frame2_finish");
    chk("frame2_nbits", bits.size() - b0, 160);
    chk("frame2_first_old", byte_at(b0), 8'h1C);
    chk("frame2_last_new", byte_at(b0 + 152), 8'h3C);
    // control and frame requested together: control first
    b0 = bits.size();
    c0 = ce_low;
    i_ctrl_valid = 1'b1;
    i_ctrl_data = 8'h4F;
    i_frame_start = 1'b1;
    @(negedge i_clk);
    i_ctrl_valid = 1'b0;
    i_frame_start = 1'b0;
    wait_done(3, "both_finish");
    chk("both_nbits", bits.size() - b0, 168);
    chk("both_ctrl_byte", byte_at(b0), 8'h4F);
    chk("both_ctrl_rs", rs_ones(b0, 8), 8);
    chk("both_frame_rs", rs_ones(b0 + 8, 160), 0);
    chk("both_frame_first", byte_at(b0 + 8), 8'hAA);
    chk("both_frame_last", byte_at(b0 + 160), 8'h3C);
    chk("both_ce_low", ce_low - c0, 676);
    // reset mid-frame at bit 50
    b0 = bits.size();
    i_frame_start = 1'b1;
    @(negedge i_clk);
    i_frame_start = 1'b0;
    n = 0;
    while (bits.size() - b0 < 50 && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    chk("midrst_reached_bit50", 32'(n < 1000), 1);
    r_reset = 1'b1;
    @(negedge i_clk);
    chk("midrst_ce_n", o_hcms_ce_n, 1);
    chk("midrst_clk", o_hcms_clk, 0);
    chk("midrst_reset_n", o_hcms_reset_n, 0);
    chk("midrst_busy", o_busy, 1);
    r_reset = 1'b0;
    hold_count("midrst_hold_len");
    repeat (30) @(negedge i_clk);
    chk("midrst_no_done", done_cnt, 3);
    chk("midrst_idle", o_busy, 0);
    chk("midrst_ready", o_ctrl_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
